// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encodings and counter width.
package pll_seq_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_PWRDN     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_ff2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta <= 1'b0;
      q_o  <= 1'b0;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: power-down, lock wait, stability check, downstream
// reset hold, then RUN; bounded retries end in FAULT until a relock request.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PD_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned RST_HOLD     = 64,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_lock_i,
  input  logic       relock_req_i,
  output logic       pll_powerdown_n_o,
  output logic       sys_rst_o,
  output logic       pll_ready_o,
  output logic       fault_o,
  output logic [3:0] retry_cnt_o,
  output logic [2:0] state_o
);

  // Terminal counts: the counter holds "cycles already spent" in the state.
  localparam logic [CNT_W-1:0] PD_LAST      = CNT_W'(PD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       retry_d;
  logic             lock_s;
  logic             attempt_fail;
  logic             pd_n_d, sys_rst_d, ready_d, fault_d;

  sync_ff2 u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pll_lock_i),
    .q_o   (lock_s)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    retry_d      = retry_cnt_o;
    attempt_fail = 1'b0;

    case (state_q)
      ST_PWRDN: begin
        if (cnt_q == PD_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s)                      state_d = ST_STABLE;
        else if (cnt_q == TIMEOUT_LAST)  attempt_fail = 1'b1;
      end
      ST_STABLE: begin
        // A dropout here only restarts the lock wait; it is not a failed attempt.
        if (!lock_s)                     state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)   state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!lock_s) begin
          attempt_fail = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          retry_d = 4'd0;
        end
      end
      ST_RUN: begin
        if (!lock_s || relock_req_i) state_d = ST_PWRDN;
      end
      ST_FAULT: begin
        if (relock_req_i) begin
          state_d = ST_PWRDN;
          retry_d = 4'd0;
        end
      end
      default: state_d = ST_PWRDN;
    endcase

    if (attempt_fail) begin
      if (retry_cnt_o == RETRY_MAX) begin
        state_d = ST_FAULT;
      end else begin
        state_d = ST_PWRDN;
        retry_d = retry_cnt_o + 4'd1;
      end
    end

    // Outputs are decoded from the next state so the registers line up with state_q.
    pd_n_d    = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) ||
                (state_d == ST_HOLD)      || (state_d == ST_RUN);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= ST_PWRDN;
      cnt_q             <= '0;
      retry_cnt_o       <= 4'd0;
      pll_powerdown_n_o <= 1'b0;
      sys_rst_o         <= 1'b1;
      pll_ready_o       <= 1'b0;
      fault_o           <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
      retry_cnt_o       <= retry_d;
      pll_powerdown_n_o <= pd_n_d;
      sys_rst_o         <= sys_rst_d;
      pll_ready_o       <= ready_d;
      fault_o           <= fault_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: a countdown-based phase model predicts every output change;
// a negedge monitor compares each observed change against the predicted queue.
module tb_pll_lock_sequencer;

  localparam int PD = 4, TO = 20, STB = 8, HD = 5, MR = 2;
  localparam int S_PWRDN = 0, S_WAIT = 1, S_STABLE = 2, S_HOLD = 3, S_RUN = 4, S_FAULT = 5;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       pll_lock_i = 1'b0;
  logic       relock_req_i = 1'b0;
  logic       pll_powerdown_n_o, sys_rst_o, pll_ready_o, fault_o;
  logic [3:0] retry_cnt_o;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int st;
    int retry;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  bit   saw_glitch = 1'b0;

  always #5 clk_i = ~clk_i;

  pll_lock_sequencer #(
    .PD_CYCLES    (PD),
    .LOCK_TIMEOUT (TO),
    .LOCK_STABLE  (STB),
    .RST_HOLD     (HD),
    .MAX_RETRY    (MR)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .pll_lock_i        (pll_lock_i),
    .relock_req_i      (relock_req_i),
    .pll_powerdown_n_o (pll_powerdown_n_o),
    .sys_rst_o         (sys_rst_o),
    .pll_ready_o       (pll_ready_o),
    .fault_o           (fault_o),
    .retry_cnt_o       (retry_cnt_o),
    .state_o           (state_o)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected {powerdown_n, sys_rst, ready, fault} for a given phase.
  function automatic logic [3:0] outs_for(int s);
    logic [3:0] r;
    r[3] = (s >= S_WAIT) && (s <= S_RUN);
    r[2] = (s != S_RUN);
    r[1] = (s == S_RUN);
    r[0] = (s == S_FAULT);
    return r;
  endfunction

  // Reference model: each phase carries "cycles remaining"; lock is seen two edges late.
  int m_ph, m_rem, m_retry, m_nph, m_nretry;
  bit m_ls, m_fail;
  bit lpipe[$];

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_ph    = S_PWRDN;
      m_rem   = PD;
      m_retry = 0;
      lpipe   = '{1'b0, 1'b0};
      exp_q.delete();
    end else begin
      cyc++;
      m_ls = lpipe.pop_front();
      lpipe.push_back(pll_lock_i);
      m_nph    = m_ph;
      m_nretry = m_retry;
      m_fail   = 1'b0;
      case (m_ph)
        S_PWRDN: begin
          m_rem--;
          if (m_rem == 0) begin m_nph = S_WAIT; m_rem = TO; end
        end
        S_WAIT: begin
          if (m_ls) begin m_nph = S_STABLE; m_rem = STB; end
          else begin m_rem--; if (m_rem == 0) m_fail = 1'b1; end
        end
        S_STABLE: begin
          if (!m_ls) begin m_nph = S_WAIT; m_rem = TO; end
          else begin
            m_rem--;
            if (m_rem == 0) begin m_nph = S_HOLD; m_rem = HD; end
          end
        end
        S_HOLD: begin
          if (!m_ls) m_fail = 1'b1;
          else begin
            m_rem--;
            if (m_rem == 0) begin m_nph = S_RUN; m_nretry = 0; end
          end
        end
        S_RUN: begin
          if (!m_ls || relock_req_i) begin m_nph = S_PWRDN; m_rem = PD; end
        end
        default: begin
          if (relock_req_i) begin m_nph = S_PWRDN; m_nretry = 0; m_rem = PD; end
        end
      endcase
      if (m_fail) begin
        if (m_retry == MR) m_nph = S_FAULT;
        else begin m_nph = S_PWRDN; m_nretry = m_retry + 1; m_rem = PD; end
      end
      if (m_nph != m_ph || m_nretry != m_retry) exp_q.push_back('{m_nph, m_nretry, cyc});
      m_ph    = m_nph;
      m_retry = m_nretry;
    end
  end

  // Monitor: any change of the output vector must match the next predicted entry.
  logic [10:0] cur_v;
  logic [10:0] prev_v = 11'b000_0000_0100;
  exp_t        e;
  assign cur_v = {state_o, retry_cnt_o, pll_powerdown_n_o, sys_rst_o, pll_ready_o, fault_o};

  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_v = cur_v;
    end else if (cur_v !== prev_v) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_change: outputs %0h, previous %0h, none predicted (t=%0t)",
                 cur_v, prev_v, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_state", state_o, e.st);
        check("sb_retry", retry_cnt_o, e.retry);
        check("sb_cycle", cyc, e.cyc);
        check("sb_outputs", {pll_powerdown_n_o, sys_rst_o, pll_ready_o, fault_o}, outs_for(e.st));
      end
      if (prev_v[10:8] == 3'd2 && state_o == 3'd1) saw_glitch = 1'b1;
      prev_v = cur_v;
    end
  end

  task automatic wait_state(int s, int budget, string name);
    int k = 0;
    while (state_o !== 3'(s) && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    check(name, state_o, s);
  endtask

  task automatic pulse_relock();
    @(negedge clk_i);
    relock_req_i = 1'b1;
    @(negedge clk_i);
    relock_req_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;

    repeat (3) @(negedge clk_i);
    check("rst_pd_n", pll_powerdown_n_o, 0);
    check("rst_sys_rst", sys_rst_o, 1);
    check("rst_ready", pll_ready_o, 0);
    check("rst_fault", fault_o, 0);
    check("rst_retry", retry_cnt_o, 0);
    check("rst_state", state_o, S_PWRDN);

    // Clean bring-up: lock rises 10 cycles after reset release.
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("pd_held_3_cycles", pll_powerdown_n_o, 0);
    @(negedge clk_i);
    check("pd_released_after_4", pll_powerdown_n_o, 1);
    repeat (6) @(negedge clk_i);
    pll_lock_i = 1'b1;
    lat = 0;
    while (sys_rst_o && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    check("bringup_latency_14_to_16", (lat >= 14 && lat <= 16), 1);
    check("bringup_ready", pll_ready_o, 1);

    // Lock loss in RUN.
    pll_lock_i = 1'b0;
    lat = 0;
    while (!sys_rst_o && lat < 10) begin
      @(negedge clk_i);
      lat++;
    end
    check("lockloss_within_3", (lat >= 1 && lat <= 3), 1);
    check("lockloss_ready", pll_ready_o, 0);
    check("lockloss_state", state_o, S_PWRDN);
    check("lockloss_retry", retry_cnt_o, 0);

    // Never lock: exhaust retries.
    wait_state(S_FAULT, 150, "neverlock_reach_fault");
    check("fault_flag", fault_o, 1);
    check("fault_pd_n", pll_powerdown_n_o, 0);
    check("fault_retry", retry_cnt_o, MR);

    pulse_relock();
    check("fault_relock_state", state_o, S_PWRDN);
    check("fault_relock_retry", retry_cnt_o, 0);

    // Glitchy lock: 5 high, 1 low, then steady.
    wait_state(S_WAIT, 10, "glitch_reach_wait");
    saw_glitch = 1'b0;
    pll_lock_i = 1'b1;
    repeat (5) @(negedge clk_i);
    pll_lock_i = 1'b0;
    @(negedge clk_i);
    pll_lock_i = 1'b1;
    wait_state(S_RUN, 100, "glitch_reach_run");
    check("glitch_stable_to_wait", saw_glitch, 1);
    check("glitch_no_retry", retry_cnt_o, 0);

    // Relock in RUN, then ignored relock in HOLD.
    pulse_relock();
    check("run_relock_state", state_o, S_PWRDN);
    check("run_relock_ready", pll_ready_o, 0);
    wait_state(S_HOLD, 60, "reach_hold");
    pulse_relock();
    check("hold_relock_ignored", state_o, S_HOLD);
    wait_state(S_RUN, 20, "hold_to_run");

    // Reset asserted mid-cycle during HOLD.
    pulse_relock();
    wait_state(S_HOLD, 60, "reach_hold_for_reset");
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_sys_rst", sys_rst_o, 1);
    check("async_rst_pd_n", pll_powerdown_n_o, 0);
    check("async_rst_state", state_o, S_PWRDN);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Random lock waveforms with occasional relock requests.
    for (int seg = 0; seg < 40; seg++) begin
      bit lv;
      int len;
      lv  = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        @(negedge clk_i);
        pll_lock_i   = lv;
        relock_req_i = ($urandom_range(0, 24) == 0);
      end
    end
    @(negedge clk_i);
    relock_req_i = 1'b0;
    pll_lock_i   = 1'b1;
    repeat (60) @(negedge clk_i);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
